// File: rtl/conv_multi_row.sv
// conv_multi_row: KERNEL_ROWS x KERNEL_SIZE windowed MAC with cascaded psum, bias, optional ReLU and saturation
module conv_multi_row #(
  parameter int KERNEL_SIZE = 5,
  parameter int KERNEL_ROWS = 5,
  parameter int WEIGHT_BW   = 8,
  parameter int DATA_BW     = 8,
  parameter int SUM_BW      = 16,
  parameter int ADDR_BW     = 5
) (
  input  logic                                   clk,
  input  logic                                   rst_n,
  input  logic                                   i_w_en,
  input  logic        [ADDR_BW-1:0]              i_addr,
  input  logic signed [WEIGHT_BW-1:0]            i_w,
  input  logic                                   i_valid,
  input  logic                                   i_line_start,
  input  logic        [KERNEL_ROWS*DATA_BW-1:0]  i_x,
  input  logic signed [SUM_BW-1:0]               i_psum,
  input  logic signed [SUM_BW-1:0]               i_bias,
  input  logic                                   i_relu,
  output logic                                   o_valid,
  output logic signed [SUM_BW-1:0]               o_psum,
  output logic                                   o_sat
);
  localparam int TAPS   = KERNEL_ROWS * KERNEL_SIZE;
  localparam int ACC_BW = WEIGHT_BW + DATA_BW + $clog2(TAPS) + 2;
  localparam int CNT_BW = $clog2(KERNEL_SIZE + 1);
  localparam logic signed [ACC_BW-1:0] MAX_V = ACC_BW'((64'sd1 <<< (SUM_BW - 1)) - 64'sd1);
  localparam logic signed [ACC_BW-1:0] MIN_V = ACC_BW'(-(64'sd1 <<< (SUM_BW - 1)));
  logic signed [WEIGHT_BW-1:0] w [KERNEL_ROWS][KERNEL_SIZE];
  logic signed [DATA_BW-1:0]   s [KERNEL_ROWS][KERNEL_SIZE];
  logic signed [ACC_BW-1:0]    row_sum [KERNEL_ROWS];
  logic signed [ACC_BW-1:0]    row_q [KERNEL_ROWS];
  logic [CNT_BW-1:0]           cnt, cnt_nxt;
  logic                        v0, v1;
  logic signed [SUM_BW-1:0]    psum0, psum1;
  logic signed [ACC_BW-1:0]    acc, acc_r;
  logic signed [SUM_BW-1:0]    sat_val;
  logic                        sat_flag;
  assign cnt_nxt = i_line_start ? CNT_BW'(1) :
                   (cnt == CNT_BW'(KERNEL_SIZE)) ? cnt : cnt + CNT_BW'(1);
  // out-of-range addresses simply match no tap and are dropped
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int r = 0; r < KERNEL_ROWS; r++)
        for (int c = 0; c < KERNEL_SIZE; c++) begin
          w[r][c] <= '0;
          s[r][c] <= '0;
        end
      cnt   <= '0;
      v0    <= 1'b0;
      psum0 <= '0;
    end else begin
      for (int r = 0; r < KERNEL_ROWS; r++)
        for (int c = 0; c < KERNEL_SIZE; c++)
          if (i_w_en && i_addr == ADDR_BW'(r * KERNEL_SIZE + c)) w[r][c] <= i_w;
      v0 <= i_valid && cnt_nxt == CNT_BW'(KERNEL_SIZE);
      if (i_valid) begin
        cnt   <= cnt_nxt;
        psum0 <= i_psum;
        for (int r = 0; r < KERNEL_ROWS; r++) begin
          for (int c = 0; c < KERNEL_SIZE - 1; c++) s[r][c] <= s[r][c+1];
          s[r][KERNEL_SIZE-1] <= i_x[r*DATA_BW +: DATA_BW];
        end
      end
    end
  end
  always_comb begin
    for (int r = 0; r < KERNEL_ROWS; r++) begin
      row_sum[r] = '0;
      for (int c = 0; c < KERNEL_SIZE; c++)
        row_sum[r] = row_sum[r] + ACC_BW'(w[r][c]) * ACC_BW'(s[r][c]);
    end
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      v1    <= 1'b0;
      psum1 <= '0;
      for (int r = 0; r < KERNEL_ROWS; r++) row_q[r] <= '0;
    end else begin
      v1    <= v0;
      psum1 <= psum0;
      for (int r = 0; r < KERNEL_ROWS; r++) row_q[r] <= row_sum[r];
    end
  end
  always_comb begin
    acc = ACC_BW'(psum1) + ACC_BW'(i_bias);
    for (int r = 0; r < KERNEL_ROWS; r++) acc = acc + row_q[r];
    acc_r    = (i_relu && acc < 0) ? '0 : acc;
    sat_flag = acc_r > MAX_V || acc_r < MIN_V;
    sat_val  = acc_r > MAX_V ? SUM_BW'(MAX_V) : acc_r < MIN_V ? SUM_BW'(MIN_V) : SUM_BW'(acc_r);
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      o_valid <= 1'b0;
      o_psum  <= '0;
      o_sat   <= 1'b0;
    end else begin
      o_valid <= v1;
      if (v1) begin
        o_psum <= sat_val;
        o_sat  <= sat_flag;
      end
    end
  end
endmodule

// File: tb/tb_conv_multi_row.sv
// tb_conv_multi_row: directed scoreboard bench for conv_multi_row
module tb_conv_multi_row;
  logic               clk = 1'b0;
  logic               rst_n;
  logic               i_w_en, i_valid, i_line_start, i_relu;
  logic [4:0]         i_addr;
  logic signed [7:0]  i_w;
  logic [39:0]        i_x;
  logic signed [15:0] i_psum, i_bias;
  logic               o_valid, o_sat;
  logic signed [15:0] o_psum;
  typedef struct {
    logic signed [15:0] p;
    logic               s;
    int                 t;
  } exp_t;
  exp_t q[$];
  int cyc = 0;
  int checks = 0;
  int errors = 0;
  conv_multi_row dut (
    .clk(clk), .rst_n(rst_n), .i_w_en(i_w_en), .i_addr(i_addr), .i_w(i_w),
    .i_valid(i_valid), .i_line_start(i_line_start), .i_x(i_x), .i_psum(i_psum),
    .i_bias(i_bias), .i_relu(i_relu), .o_valid(o_valid), .o_psum(o_psum), .o_sat(o_sat)
  );
  always #5 clk = ~clk;
  always @(posedge clk) cyc++;
  function automatic logic [39:0] allx(input int v);
    logic [7:0] b;
    b = 8'(v);
    return {5{b}};
  endfunction
  function automatic logic [39:0] r0(input int v);
    logic [7:0] b;
    b = 8'(v);
    return {32'd0, b};
  endfunction
  function automatic logic [39:0] r1(input int v);
    logic [7:0] b;
    b = 8'(v);
    return {24'd0, b, 8'd0};
  endfunction
  task automatic chk(input string name, input int got, input int want);
    checks++;
    if (got != want) begin
      errors++;
      $display("FAIL %s got=%0d want=%0d", name, got, want);
    end
  endtask
  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask
  task automatic wr(input int a, input int v);
    i_w_en = 1'b1;
    i_addr = 5'(a);
    i_w    = 8'(v);
    @(negedge clk);
    i_w_en = 1'b0;
  endtask
  task automatic wall(input int v);
    for (int i = 0; i < 25; i++) wr(i, v);
  endtask
  task automatic smp(input logic [39:0] x, input bit ls, input int ps,
                     input bit ev, input int ep, input bit es);
    exp_t e;
    i_valid = 1'b1;
    i_x = x;
    i_line_start = ls;
    i_psum = 16'(ps);
    if (ev) begin
      e.p = 16'(ep);
      e.s = es;
      e.t = cyc + 3;
      q.push_back(e);
    end
    @(negedge clk);
    i_valid = 1'b0;
    i_line_start = 1'b0;
  endtask
  task automatic mon();
    exp_t e;
    if (q.size() != 0 && q[0].t < cyc) begin
      checks++;
      errors++;
      $display("FAIL missing_out want=%0d due=%0d now=%0d", q[0].p, q[0].t, cyc);
      void'(q.pop_front());
    end
    if (rst_n && o_valid) begin
      checks++;
      if (q.size() == 0) begin
        errors++;
        $display("FAIL unexpected_out got=%0d sat=%0d cyc=%0d want=none", o_psum, o_sat, cyc);
      end else begin
        e = q.pop_front();
        if (o_psum !== e.p || o_sat !== e.s || cyc != e.t) begin
          errors++;
          $display("FAIL result got=%0d sat=%0d cyc=%0d want=%0d sat=%0d cyc=%0d",
                   o_psum, o_sat, cyc, e.p, e.s, e.t);
        end
      end
    end
  endtask
  initial begin
    rst_n = 1'b0;
    i_w_en = 0; i_addr = '0; i_w = '0; i_valid = 0; i_line_start = 0;
    i_x = '0; i_psum = '0; i_bias = '0; i_relu = 0;
    fork
      forever @(negedge clk) mon();
      begin
        idle(2);
        chk("reset_valid", int'(o_valid), 0);
        chk("reset_psum", int'(o_psum), 0);
        chk("reset_sat", int'(o_sat), 0);
        rst_n = 1'b1;
        idle(1);
        // all-ones kernel
        wall(1);
        for (int i = 0; i < 5; i++) smp(allx(1), i == 0, 0, i == 4, 25, 0);
        idle(4);
        // ramp weights, row 0 only, psum and negative bias
        i_bias = -16'sd10;
        for (int i = 0; i < 25; i++) wr(i, i % 5 + 1);
        for (int i = 0; i < 6; i++) smp(r0(i + 1), i == 0, 100, i >= 4, i == 4 ? 145 : 160, 0);
        idle(4);
        // same stream with gaps
        for (int i = 0; i < 6; i++) begin
          smp(r0(i + 1), i == 0, 100, i >= 4, i == 4 ? 145 : 160, 0);
          idle(i % 3);
        end
        idle(4);
        // line restart after 3 samples
        for (int i = 0; i < 3; i++) smp(r0(9), i == 0, 100, 0, 0, 0);
        for (int i = 0; i < 5; i++) smp(r0(i + 1), i == 0, 100, i == 4, 145, 0);
        idle(4);
        // weight write coincident with accept, then out-of-range writes
        i_bias = '0;
        for (int i = 0; i < 5; i++) begin
          if (i == 4) begin
            i_w_en = 1'b1;
            i_addr = 5'd7;
            i_w = 8'sd20;
          end
          smp(r1(1), i == 0, 0, i == 4, 32, 0);
          i_w_en = 1'b0;
        end
        for (int a = 25; a < 32; a++) wr(a, 99);
        for (int i = 0; i < 5; i++) smp(allx(1), i == 0, 0, i == 4, 92, 0);
        idle(4);
        // saturation both ways and ReLU
        wall(127);
        for (int i = 0; i < 5; i++) smp(allx(127), i == 0, 0, i == 4, 32767, 1);
        idle(4);
        wall(-128);
        for (int i = 0; i < 5; i++) smp(allx(127), i == 0, 0, i == 4, -32768, 1);
        idle(4);
        i_relu = 1'b1;
        smp(allx(127), 0, 0, 1, 0, 0);
        idle(4);
        i_relu = 1'b0;
        // reset with two results in flight
        for (int i = 0; i < 6; i++) smp(allx(1), i == 0, 0, 0, 0, 0);
        rst_n = 1'b0;
        q.delete();
        idle(1);
        rst_n = 1'b1;
        for (int i = 0; i < 3; i++) begin
          chk("post_reset_valid", int'(o_valid), 0);
          chk("post_reset_psum", int'(o_psum), 0);
          idle(1);
        end
        for (int i = 0; i < 5; i++) smp(allx(1), i == 0, 0, i == 4, 0, 0);
        idle(5);
        chk("queue_drained", q.size(), 0);
      end
    join_any
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
